// File: rtl/qspi_pkg.sv
// qspi_pkg: command codes, responder states and defaults shared by the QSPI controller and responder
package qspi_pkg;
  localparam logic [7:0] RID_CMD = 8'h9F;
  localparam logic [7:0] RDSR_CMD = 8'h05;
  localparam logic [7:0] READ_CMD = 8'h03;
  localparam logic [23:0] DEFAULT_JEDEC_ID = 24'hEF4018;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, ID_OUT, STAT_OUT, RD_OUT, IGNORE} state_t;
  function automatic state_t cmd_branch(input logic [7:0] c);
    return c == RID_CMD ? ID_OUT : c == RDSR_CMD ? STAT_OUT : c == READ_CMD ? ADDR : IGNORE;
  endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchronizer plus edge register; registered rise/fall pulses line up with q
module spi_pin_sync #(
  parameter int W = 1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] s1, s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= INIT;
      s2 <= INIT;
      q <= INIT;
      rise <= '0;
      fall <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      q <= s2;
      rise <= s2 & ~q;
      fall <= ~s2 & q;
    end
  end
endmodule

// File: rtl/qspi_id_resp.sv
// qspi_id_resp: mode-0 SPI flash stand-in answering Read-ID, Read-Status and Read-Data
module qspi_id_resp
  import qspi_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID = DEFAULT_JEDEC_ID,
  parameter logic [7:0] STATUS_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        ce,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        mem_rd_en,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata
);
  logic [2:0] pin_q, pin_r, pin_f;
  logic ce_hi, mosi_s, sck_rise, sck_fall, unused;
  state_t state, state_d;
  logic [4:0] cnt;
  logic [23:0] sr;
  logic [7:0] osr, pf_buf, nb, cmd_byte;
  logic [2:0] ocnt;
  logic [1:0] bidx;
  logic pend, last_cmd, last_addr, out_st;
  // ce resets to its inactive (high) level so reset never looks like a frame start
  spi_pin_sync #(.W(3), .INIT(3'b010)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .d({sck, ce, mosi}),
    .q(pin_q),
    .rise(pin_r),
    .fall(pin_f)
  );
  assign ce_hi = pin_q[1];
  assign mosi_s = pin_q[0];
  assign sck_rise = pin_r[2];
  assign sck_fall = pin_f[2];
  assign unused = ^{pin_q[2], pin_r[1:0], pin_f[1:0]};
  assign cmd_byte = {sr[6:0], mosi_s};
  assign last_cmd = state == CMD && sck_rise && cnt == 5'd7;
  assign last_addr = state == ADDR && sck_rise && cnt == 5'd23;
  assign out_st = state inside {ID_OUT, STAT_OUT, RD_OUT};
  assign nb = state == ID_OUT ? (bidx == 2'd0 ? JEDEC_ID[23:16] : bidx == 2'd1 ? JEDEC_ID[15:8] : JEDEC_ID[7:0]) :
              state == STAT_OUT ? STATUS_VAL : pf_buf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    if (ce_hi) state_d = IDLE;
    else if (state == IDLE) state_d = CMD;
    else if (last_cmd) state_d = cmd_branch(cmd_byte);
    else if (last_addr) state_d = RD_OUT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso <= 1'b0;
      miso_oe <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code <= 8'h00;
      mem_rd_en <= 1'b0;
      mem_addr <= 24'h0;
      cnt <= '0;
      sr <= '0;
      osr <= '0;
      ocnt <= '0;
      bidx <= '0;
      pf_buf <= '0;
      pend <= 1'b0;
    end else begin
      cmd_valid <= last_cmd && !ce_hi;
      mem_rd_en <= 1'b0;
      pend <= mem_rd_en && !ce_hi;
      if (pend && !ce_hi) pf_buf <= mem_rdata;
      if (ce_hi || state == IDLE) begin
        cnt <= '0;
        sr <= '0;
        ocnt <= '0;
        bidx <= '0;
        miso <= 1'b0;
        miso_oe <= 1'b0;
      end else begin
        if (sck_rise && (state == CMD || state == ADDR)) begin
          sr <= {sr[22:0], mosi_s};
          cnt <= (last_cmd || last_addr) ? 5'd0 : cnt + 5'd1;
        end
        if (last_cmd) cmd_code <= cmd_byte;
        if (last_addr) begin
          mem_rd_en <= 1'b1;
          mem_addr <= {sr[22:0], mosi_s};
        end
        if (sck_fall && out_st) begin
          miso <= ocnt == 3'd0 ? nb[7] : osr[7];
          osr <= ocnt == 3'd0 ? {nb[6:0], 1'b0} : {osr[6:0], 1'b0};
          ocnt <= ocnt + 3'd1;
          miso_oe <= 1'b1;
          // byte boundary: advance ID byte, and for reads refill the prefetch buffer
          if (ocnt == 3'd0) begin
            bidx <= bidx == 2'd2 ? 2'd0 : bidx + 2'd1;
            if (state == RD_OUT) begin
              mem_addr <= mem_addr + 24'd1;
              mem_rd_en <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule
